// File: rtl/rfid_wb_fabric.sv
// Wishbone classic single-master fabric for the RFID front end.
// Decodes slave index, times out stuck slaves, hosts IRQ/ERR bank.
module rfid_wb_fabric #(
  parameter  int NSLV    = 4,
  parameter  int AW      = 3,
  parameter  int DW      = 8,
  parameter  int TIMEOUT = 255,
  localparam int SW      = $clog2(NSLV + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               m_cyc_i,
  input  logic               m_stb_i,
  input  logic [SW+AW-1:0]   m_adr_i,
  input  logic               m_we_i,
  input  logic [DW-1:0]      m_dat_i,
  output logic [DW-1:0]      m_dat_o,
  output logic               m_ack_o,
  output logic               m_err_o,
  output logic               m_inta_o,
  output logic               s_cyc_o,
  output logic [NSLV-1:0]    s_stb_o,
  output logic [AW-1:0]      s_adr_o,
  output logic               s_we_o,
  output logic [DW-1:0]      s_dat_o,
  input  logic [NSLV*DW-1:0] s_dat_i,
  input  logic [NSLV-1:0]    s_ack_i,
  input  logic [NSLV-1:0]    s_inta_i
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  localparam logic [SW-1:0] BANK    = SW'(NSLV);
  localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [NSLV-1:0] mask_q, mask_d;
  logic [NSLV-1:0] stat_q;
  logic            inta_q;
  logic            eflag_q, eflag_d;
  logic [SW-1:0]   eidx_q, eidx_d;

  logic [SW-1:0]   req_idx;
  logic [AW-1:0]   req_off;
  logic            ack_sel;
  logic [DW-1:0]   rd_sel;
  logic [NSLV-1:0] stb_sel;
  logic [DW-1:0]   errv;
  logic [DW-1:0]   bank_rd;

  assign req_idx = m_adr_i[SW+AW-1:AW];
  assign req_off = m_adr_i[AW-1:0];

  // Route ack/data of the selected slave and build its strobe
  always_comb begin
    ack_sel = 1'b0;
    rd_sel  = '0;
    stb_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q == SW'(i)) begin
        ack_sel    = s_ack_i[i];
        rd_sel     = s_dat_i[i*DW +: DW];
        stb_sel[i] = 1'b1;
      end
    end
  end

  // Internal register bank read mux
  always_comb begin
    errv         = '0;
    errv[SW-1:0] = eidx_q;
    errv[DW-1]   = eflag_q;
    bank_rd      = '0;
    unique case (1'b1)
      (req_off == AW'(0)): bank_rd = DW'(mask_q);
      (req_off == AW'(1)): bank_rd = DW'(stat_q);
      (req_off == AW'(2)): bank_rd = errv;
      default:             bank_rd = '0;
    endcase
  end

  // Next-state and transfer control
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rdat_d  = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    eflag_d = eflag_q;
    eidx_d  = eidx_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m_cyc_i && m_stb_i) begin
          sel_d  = req_idx;
          adr_d  = req_off;
          we_d   = m_we_i;
          wdat_d = m_dat_i;
          if (req_idx < BANK) begin
            state_d = XFER;
          end else if (req_idx == BANK) begin
            state_d = DONE;
            ack_d   = 1'b1;
            if (m_we_i) begin
              if (req_off == AW'(0)) mask_d = m_dat_i[NSLV-1:0];
              if (req_off == AW'(2)) begin
                eflag_d = 1'b0;
                eidx_d  = '0;
              end
            end else begin
              rdat_d = bank_rd;
            end
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      XFER: begin
        if (!m_cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (ack_sel) begin
          state_d = DONE;
          ack_d   = 1'b1;
          rdat_d  = rd_sel;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          eflag_d = 1'b1;
          eidx_d  = sel_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= '0;
      stat_q  <= '0;
      inta_q  <= 1'b0;
      eflag_q <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      stat_q  <= s_inta_i & mask_q;
      inta_q  <= |(s_inta_i & mask_q);
      eflag_q <= eflag_d;
      eidx_q  <= eidx_d;
    end
  end

  assign m_dat_o  = rdat_q;
  assign m_ack_o  = ack_q;
  assign m_err_o  = err_q;
  assign m_inta_o = inta_q;
  assign s_cyc_o  = (state_q == XFER);
  assign s_stb_o  = (state_q == XFER) ? stb_sel : '0;
  assign s_adr_o  = adr_q;
  assign s_we_o   = we_q;
  assign s_dat_o  = wdat_q;

endmodule

// File: tb/tb_rfid_wb_fabric.sv
// Bench for rfid_wb_fabric: directed master transfers, slave models,
// and a response scoreboard fed by the stimulus.
module tb_rfid_wb_fabric;

  localparam int NSLV = 4;
  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int TO   = 16;
  localparam int SW   = $clog2(NSLV + 1);

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               m_cyc_i, m_stb_i, m_we_i;
  logic [SW+AW-1:0]   m_adr_i;
  logic [DW-1:0]      m_dat_i, m_dat_o;
  logic               m_ack_o, m_err_o, m_inta_o;
  logic               s_cyc_o, s_we_o;
  logic [NSLV-1:0]    s_stb_o, s_ack_i, s_inta_i;
  logic [AW-1:0]      s_adr_o;
  logic [DW-1:0]      s_dat_o;
  logic [NSLV*DW-1:0] s_dat_i;

  rfid_wb_fabric #(
    .NSLV(NSLV), .AW(AW), .DW(DW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_adr_i(m_adr_i), .m_we_i(m_we_i),
    .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_inta_o(m_inta_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_adr_o(s_adr_o),
    .s_we_o(s_we_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_inta_i(s_inta_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int            dly  [NSLV];
  logic [DW-1:0] sdat [NSLV];
  int            scnt [NSLV];

  // slave models: ack on strobe cycle number dly (0 = first), -1 never
  always @(posedge clk_i) begin
    for (int i = 0; i < NSLV; i++)
      scnt[i] <= s_stb_o[i] ? scnt[i] + 1 : 0;
  end

  always_comb begin
    s_ack_i = '0;
    s_dat_i = '0;
    for (int i = 0; i < NSLV; i++) begin
      s_ack_i[i]         = s_stb_o[i] && (scnt[i] == dly[i]);
      s_dat_i[i*DW +: DW] = sdat[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // monitor: every ack/err pops one expected response
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && (m_ack_o || m_err_o)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'({m_err_o, m_ack_o}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_kind", 32'({m_err_o, m_ack_o}),
            e.err ? 32'd2 : 32'd1);
        chk("resp_dat", 32'(m_dat_o), 32'(e.dat));
      end
    end
  end

  task automatic txn(input int idx, input int off, input logic we,
                     input logic [DW-1:0] wd, input logic xerr,
                     input logic [DW-1:0] xdat, output int xcyc,
                     output bit held, output logic [NSLV-1:0] stb_or);
    exp_t e;
    bit   got;
    e.err = xerr;
    e.dat = xdat;
    exp_q.push_back(e);
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_adr_i = {SW'(idx), AW'(off)};
    m_we_i  = we;
    m_dat_i = wd;
    xcyc    = 0;
    held    = 1'b1;
    stb_or  = '0;
    got     = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk_i);
      #1;
      stb_or = stb_or | s_stb_o;
      if (s_cyc_o) begin
        xcyc++;
        if (s_we_o !== we || s_dat_o !== wd || s_adr_o !== AW'(off))
          held = 1'b0;
      end
      if (m_ack_o || m_err_o) begin
        got = 1'b1;
        break;
      end
    end
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    m_we_i  = 1'b0;
    m_dat_i = '0;
    if (!got) chk("txn_no_response", 32'd0, 32'd1);
  endtask

  task automatic bank(input int off, input logic we,
                      input logic [DW-1:0] wd, input logic [DW-1:0] xd);
    int xc;
    bit hd;
    logic [NSLV-1:0] so;
    txn(NSLV, off, we, wd, 1'b0, xd, xc, hd, so);
    chk("bank_no_stb", 32'(so), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got 0x0 want 0x1");
    $fatal(1, "watchdog");
  end

  initial begin
    int xc;
    bit hd;
    logic [NSLV-1:0] so;
    rst_i    = 1'b1;
    m_cyc_i  = 1'b0;
    m_stb_i  = 1'b0;
    m_we_i   = 1'b0;
    m_adr_i  = '0;
    m_dat_i  = '0;
    s_inta_i = '0;
    for (int i = 0; i < NSLV; i++) begin
      dly[i]  = -1;
      sdat[i] = '0;
    end
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ctl", 32'({m_ack_o, m_err_o, m_inta_o, s_cyc_o,
                        s_stb_o, s_we_o}), 32'd0);
    chk("rst_dat", 32'({s_adr_o, s_dat_o, m_dat_o}), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // read slave 2 offset 5, ack on first strobe cycle
    sdat[2] = 8'hA5;
    dly[2]  = 0;
    txn(2, 5, 1'b0, 8'h00, 1'b0, 8'hA5, xc, hd, so);
    chk("rd2_xcyc", 32'(xc), 32'd1);
    chk("rd2_stb", 32'(so), 32'b0100);
    chk("rd2_held", 32'(hd), 32'd1);

    // write slave 1 offset 0, ack on 6th strobe cycle
    sdat[1] = 8'h11;
    dly[1]  = 5;
    txn(1, 0, 1'b1, 8'h3C, 1'b0, 8'h11, xc, hd, so);
    chk("wr1_xcyc", 32'(xc), 32'd6);
    chk("wr1_stb", 32'(so), 32'b0010);
    chk("wr1_held", 32'(hd), 32'd1);

    // slave 3 never acks -> timeout
    sdat[3] = 8'hEE;
    txn(3, 1, 1'b0, 8'h00, 1'b1, 8'h00, xc, hd, so);
    chk("to_xcyc", 32'(xc), 32'(TO));
    chk("to_stb", 32'(so), 32'b1000);
    bank(2, 1'b0, 8'h00, 8'h83);
    bank(2, 1'b1, 8'h5A, 8'h00);
    bank(2, 1'b0, 8'h00, 8'h00);

    // interrupts
    bank(0, 1'b1, 8'h05, 8'h00);
    s_inta_i = 4'b0111;
    chk("inta_pre", 32'(m_inta_o), 32'd0);
    @(posedge clk_i);
    #1;
    chk("inta_on", 32'(m_inta_o), 32'd1);
    bank(1, 1'b0, 8'h00, 8'h05);
    bank(0, 1'b0, 8'h00, 8'h05);
    bank(0, 1'b1, 8'h00, 8'h00);
    @(posedge clk_i);
    #1;
    chk("inta_off", 32'(m_inta_o), 32'd0);
    bank(1, 1'b1, 8'hFF, 8'h00);
    bank(1, 1'b0, 8'h00, 8'h00);
    bank(6, 1'b0, 8'h00, 8'h00);

    // bad indices
    txn(7, 0, 1'b0, 8'h00, 1'b1, 8'h00, xc, hd, so);
    chk("bad7_xcyc", 32'(xc), 32'd0);
    chk("bad7_stb", 32'(so), 32'd0);
    txn(5, 3, 1'b1, 8'h42, 1'b1, 8'h00, xc, hd, so);
    chk("bad5_stb", 32'(so), 32'd0);

    // abort in XFER
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_adr_i = {SW'(0), AW'(2)};
    repeat (3) @(posedge clk_i);
    #1;
    chk("abort_stb", 32'({s_cyc_o, s_stb_o}), 32'b10001);
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("abort_idle", 32'(s_cyc_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    bank(2, 1'b0, 8'h00, 8'h00);

    // reset mid-XFER
    bank(0, 1'b1, 8'h0F, 8'h00);
    dly[1] = -1;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_we_i  = 1'b1;
    m_dat_i = 8'h77;
    m_adr_i = {SW'(1), AW'(3)};
    repeat (3) @(posedge clk_i);
    #1;
    chk("prerst_xfer", 32'({s_cyc_o, m_inta_o}), 32'b11);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("async_rst", 32'({m_ack_o, m_err_o, m_inta_o, s_cyc_o,
                          s_stb_o, s_we_o, s_adr_o}), 32'd0);
    chk("async_rst_dat", 32'({s_dat_o, m_dat_o}), 32'd0);
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    m_we_i  = 1'b0;
    m_dat_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("post_rst_inta", 32'(m_inta_o), 32'd0);
    bank(0, 1'b0, 8'h00, 8'h00);
    s_inta_i = '0;
    sdat[2]  = 8'h5A;
    dly[2]   = 2;
    txn(2, 4, 1'b0, 8'h00, 1'b0, 8'h5A, xc, hd, so);
    chk("post_rst_xcyc", 32'(xc), 32'd3);
    chk("post_rst_stb", 32'(so), 32'b0100);

    repeat (3) @(posedge clk_i);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
